led_bank_arbiter: RTL and testbench



---
 rtl/led_pkg.sv | 12 +
 rtl/led_bank_arbiter_rr_pick.sv | 32 +++
 rtl/led_bank_arbiter.sv | 116 +++++++++++
 tb/tb_led_bank_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED bank arbiter and related status muxes.
package led_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int                           LED_W_DEFAULT        = 8;
   localparam logic [LED_W_DEFAULT-1:0]     IDLE_PATTERN_DEFAULT = 8'h01;

endpackage

// File: rtl/led_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first request above ptr (wrapping), with
// an exclude mask so the current owner can be skipped on handover.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic [NUM_REQ-1:0] exclude,
   output logic               valid,
   output logic [IDX_W-1:0]   winner
);

   logic [NUM_REQ-1:0] cand;
   logic [IDX_W-1:0]   idx;

   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx    = '0;
      cand   = req & ~exclude;
      // i runs 1..NUM_REQ so ptr itself is considered last
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (!valid && cand[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the board LED bank with a minimum dwell per grant so
// each status source stays readable; led_o is the registered owner pattern.
module led_bank_arbiter
   import led_pkg::*;
#(
   parameter int               NUM_REQ      = 4,
   parameter int               LED_W        = LED_W_DEFAULT,
   parameter int               DWELL_CYCLES = 25000000,
   parameter logic [LED_W-1:0] IDLE_PATTERN = LED_W'(IDLE_PATTERN_DEFAULT)
) (
   input  logic                     clk_25mhz,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*LED_W-1:0] pattern_i,
   output logic [NUM_REQ-1:0]       grant_o,
   output logic [LED_W-1:0]         led_o,
   output logic                     busy_o,
   output logic                     done_o
);

   localparam int               IDX_W    = $clog2(NUM_REQ);
   localparam int               CNT_W    = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   arb_state_e         state, state_next;
   logic [IDX_W-1:0]   ptr, ptr_next;       // last winner; is the owner while in GRANT
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic [NUM_REQ-1:0] grant_next, exclude;
   logic [LED_W-1:0]   led_next;
   logic               done_next, owner_req, pick_valid;
   logic [IDX_W-1:0]   pick_idx;
   logic [LED_W-1:0]   pat [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_pat
      assign pat[k] = pattern_i[k*LED_W +: LED_W];
   end

   assign owner_req = req_i[ptr];
   assign exclude   = (state == GRANT && owner_req) ? (NUM_REQ'(1) << ptr) : '0;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req     (req_i),
      .ptr     (ptr),
      .exclude (exclude),
      .valid   (pick_valid),
      .winner  (pick_idx)
   );

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      cnt_next   = cnt;
      grant_next = grant_o;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_next = GRANT;
               ptr_next   = pick_idx;
               cnt_next   = RELOAD;
               grant_next = NUM_REQ'(1) << pick_idx;
            end
         end
         GRANT: begin
            // Owner release wins over dwell expiry
            if (!owner_req) begin
               done_next = 1'b1;
               if (pick_valid) begin
                  ptr_next   = pick_idx;
                  cnt_next   = RELOAD;
                  grant_next = NUM_REQ'(1) << pick_idx;
               end else begin
                  state_next = IDLE;
                  grant_next = '0;
               end
            end else if (cnt == '0) begin
               cnt_next = RELOAD;
               if (pick_valid) begin
                  done_next  = 1'b1;
                  ptr_next   = pick_idx;
                  grant_next = NUM_REQ'(1) << pick_idx;
               end
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
      led_next = (state == GRANT && state_next == GRANT) ? pat[ptr] : IDLE_PATTERN;
   end

   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= LAST_IDX;
         cnt     <= '0;
         grant_o <= '0;
         led_o   <= IDLE_PATTERN;
         done_o  <= 1'b0;
      end else begin
         state   <= state_next;
         ptr     <= ptr_next;
         cnt     <= cnt_next;
         grant_o <= grant_next;
         led_o   <= led_next;
         done_o  <= done_next;
      end
   end

   assign busy_o = (state == GRANT);

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: directed scenarios plus random traffic, all
// compared against an owner/elapsed-cycle model of the arbitration rules.
module tb_led_bank_arbiter;

   localparam int         NREQ     = 4;
   localparam int         LW       = 8;
   localparam int         DWELL    = 4;
   localparam logic [7:0] IDLE_PAT = 8'h01;

   logic        clk_25mhz = 1'b0;
   logic        rst_n;
   logic [3:0]  req_i     = '0;
   logic [31:0] pattern_i = 32'h44_33_22_11;
   logic [3:0]  grant_o;
   logic [7:0]  led_o;
   logic        busy_o, done_o;

   int checks   = 0;
   int failures = 0;

   int         m_owner   = -1;
   int         m_ptr     = NREQ - 1;
   int         m_elapsed = 0;
   logic [3:0] m_grant   = '0;
   logic       m_busy    = 1'b0;
   logic       m_done    = 1'b0;
   logic [7:0] m_led     = IDLE_PAT;

   led_bank_arbiter #(
      .NUM_REQ      (NREQ),
      .LED_W        (LW),
      .DWELL_CYCLES (DWELL),
      .IDLE_PATTERN (IDLE_PAT)
   ) dut (
      .clk_25mhz (clk_25mhz),
      .rst_n     (rst_n),
      .req_i     (req_i),
      .pattern_i (pattern_i),
      .grant_o   (grant_o),
      .led_o     (led_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   always #5 clk_25mhz = ~clk_25mhz;

   function automatic int rr_next(input logic [3:0] r, input int from, input int skip);
      for (int i = 1; i <= NREQ; i++) begin
         int idx;
         idx = (from + i) % NREQ;
         if (r[idx] && idx != skip) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner   = -1;
      m_ptr     = NREQ - 1;
      m_elapsed = 0;
      m_grant   = '0;
      m_busy    = 1'b0;
      m_done    = 1'b0;
      m_led     = IDLE_PAT;
   endtask

   // One clock edge of the arbitration rules, using the values sampled at it.
   task automatic model_step(input logic [3:0] r, input logic [31:0] p);
      int w;
      int old;
      old    = m_owner;
      m_done = 1'b0;
      if (m_owner < 0) begin
         m_led = IDLE_PAT;
         w = rr_next(r, m_ptr, -1);
         if (w >= 0) begin
            m_owner = w; m_ptr = w; m_elapsed = 0;
         end
      end else if (!r[m_owner]) begin
         m_done = 1'b1;
         w = rr_next(r, m_ptr, -1);
         if (w >= 0) begin
            m_led = p[old*8 +: 8];
            m_owner = w; m_ptr = w; m_elapsed = 0;
         end else begin
            m_led   = IDLE_PAT;
            m_owner = -1;
         end
      end else begin
         m_led = p[old*8 +: 8];
         m_elapsed++;
         if (m_elapsed == DWELL) begin
            m_elapsed = 0;
            w = rr_next(r, m_ptr, m_owner);
            if (w >= 0) begin
               m_done = 1'b1; m_owner = w; m_ptr = w;
            end
         end
      end
      m_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      m_busy  = (m_owner >= 0);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic [3:0] r);
      req_i = r;
      @(posedge clk_25mhz);
      model_step(req_i, pattern_i);
      @(negedge clk_25mhz);
   endtask

   task automatic do_reset();
      @(negedge clk_25mhz);
      req_i = '0;
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk_25mhz);
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({grant_o, busy_o, done_o, led_o} !== {4'b0000, 1'b0, 1'b0, IDLE_PAT}) begin
         failures++;
         $display("FAIL reset_values: got %h want %h", {grant_o, busy_o, done_o, led_o},
                  {4'b0000, 1'b0, 1'b0, IDLE_PAT});
      end
      @(negedge clk_25mhz);
      #2 rst_n = 1'b1;
      @(negedge clk_25mhz);
      model_reset();
      step(4'b0000);
      checks++;
      if ({grant_o, busy_o, done_o, led_o} !== {m_grant, m_busy, m_done, m_led}) begin
         failures++;
         $display("FAIL idle_no_req: got %h want %h", {grant_o, busy_o, done_o, led_o},
                  {m_grant, m_busy, m_done, m_led});
      end
   endtask

   task automatic test_first_grant();
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         step(4'b0101);
         checks++;
         if ({grant_o, busy_o, done_o, led_o} !== {m_grant, m_busy, m_done, m_led}) begin
            failures++;
            $display("FAIL first_grant step %0d: got %h want %h", k,
                     {grant_o, busy_o, done_o, led_o}, {m_grant, m_busy, m_done, m_led});
         end
         if (k == 1 || k == 2 || k == 5) begin
            checks++;
            if ((k == 1 && grant_o !== 4'b0001) || (k == 2 && led_o !== pattern_i[7:0]) ||
                (k == 5 && {done_o, grant_o} !== 5'b1_0100)) begin
               failures++;
               $display("FAIL first_grant_fixed step %0d: got grant=%b led=%h done=%b", k,
                        grant_o, led_o, done_o);
            end
         end
      end
   endtask

   task automatic test_solo_hold();
      int dones;
      dones = 0;
      do_reset();
      for (int k = 1; k <= 13; k++) begin
         step(4'b0010);
         if (done_o) dones++;
         checks++;
         if ({grant_o, busy_o, done_o, led_o} !== {m_grant, m_busy, m_done, m_led} ||
             grant_o !== 4'b0010) begin
            failures++;
            $display("FAIL solo_hold step %0d: got %h want %h", k,
                     {grant_o, busy_o, done_o, led_o}, {m_grant, m_busy, m_done, m_led});
         end
      end
      checks++;
      if (dones !== 0) begin
         failures++;
         $display("FAIL solo_no_done: got %0d pulses want 0", dones);
      end
   endtask

   task automatic test_owner_drop();
      logic [3:0] seq [9];
      int         g2_cycles;
      seq = '{4'b0101, 4'b0101, 4'b0100, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110};
      g2_cycles = 0;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         step(seq[k]);
         if (grant_o === 4'b0100) g2_cycles++;
         checks++;
         if ({grant_o, busy_o, done_o, led_o} !== {m_grant, m_busy, m_done, m_led}) begin
            failures++;
            $display("FAIL owner_drop step %0d: got %h want %h", k,
                     {grant_o, busy_o, done_o, led_o}, {m_grant, m_busy, m_done, m_led});
         end
         if (k == 2) begin
            checks++;
            if ({done_o, grant_o} !== 5'b1_0100) begin
               failures++;
               $display("FAIL owner_drop_handover: got done=%b grant=%b want 1 0100", done_o, grant_o);
            end
         end
      end
      checks++;
      if (g2_cycles !== DWELL || grant_o !== 4'b0010) begin
         failures++;
         $display("FAIL owner_drop_dwell: got %0d cycles then %b want %0d then 0010",
                  g2_cycles, grant_o, DWELL);
      end
   endtask

   task automatic test_all_request();
      int order [5];
      int dones;
      order = '{0, 1, 2, 3, 0};
      dones = 0;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         step(4'b1111);
         if (done_o) dones++;
         checks++;
         if ({grant_o, busy_o, done_o, led_o} !== {m_grant, m_busy, m_done, m_led}) begin
            failures++;
            $display("FAIL all_req step %0d: got %h want %h", k,
                     {grant_o, busy_o, done_o, led_o}, {m_grant, m_busy, m_done, m_led});
         end
         if (k % 4 == 1) begin
            checks++;
            if (grant_o !== 4'(1 << order[k/4])) begin
               failures++;
               $display("FAIL all_req_order step %0d: got %b want %b", k, grant_o,
                        4'(1 << order[k/4]));
            end
         end
      end
      checks++;
      if (dones !== 4) begin
         failures++;
         $display("FAIL all_req_dones: got %0d want 4", dones);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(4'b0001);
      step(4'b0001);
      #2 rst_n = 1'b0;
      req_i = '0;
      #1;
      checks++;
      if ({grant_o, busy_o, done_o, led_o} !== {4'b0000, 1'b0, 1'b0, IDLE_PAT}) begin
         failures++;
         $display("FAIL async_reset_now: got %h want %h", {grant_o, busy_o, done_o, led_o},
                  {4'b0000, 1'b0, 1'b0, IDLE_PAT});
      end
      @(negedge clk_25mhz);
      checks++;
      if ({grant_o, busy_o, done_o, led_o} !== {4'b0000, 1'b0, 1'b0, IDLE_PAT}) begin
         failures++;
         $display("FAIL async_reset_held: got %h want %h", {grant_o, busy_o, done_o, led_o},
                  {4'b0000, 1'b0, 1'b0, IDLE_PAT});
      end
      #2 rst_n = 1'b1;
      @(negedge clk_25mhz);
      model_reset();
      step(4'b1000);
      checks++;
      if (grant_o !== 4'b1000 || {grant_o, busy_o, done_o, led_o} !== {m_grant, m_busy, m_done, m_led}) begin
         failures++;
         $display("FAIL async_reset_regrant: got %h want %h", {grant_o, busy_o, done_o, led_o},
                  {m_grant, m_busy, m_done, m_led});
      end
   endtask

   task automatic test_pattern_track();
      do_reset();
      pattern_i[7:0] = 8'hA5;
      step(4'b0001);
      step(4'b0001);
      checks++;
      if (led_o !== 8'hA5) begin
         failures++;
         $display("FAIL pattern_a5: got %h want a5", led_o);
      end
      pattern_i[7:0] = 8'h5A;
      step(4'b0001);
      checks++;
      if (led_o !== 8'h5A || m_led !== 8'h5A) begin
         failures++;
         $display("FAIL pattern_5a: got %h want 5a", led_o);
      end
      step(4'b0000);
      checks++;
      if ({grant_o, busy_o, done_o, led_o} !== {4'b0000, 1'b0, 1'b1, IDLE_PAT}) begin
         failures++;
         $display("FAIL pattern_release: got %h want %h", {grant_o, busy_o, done_o, led_o},
                  {4'b0000, 1'b0, 1'b1, IDLE_PAT});
      end
      step(4'b0000);
      checks++;
      if ({grant_o, busy_o, done_o, led_o} !== {4'b0000, 1'b0, 1'b0, IDLE_PAT}) begin
         failures++;
         $display("FAIL pattern_idle: got %h want %h", {grant_o, busy_o, done_o, led_o},
                  {4'b0000, 1'b0, 1'b0, IDLE_PAT});
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      do_reset();
      r = 4'($urandom);
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom);
         if ($urandom_range(0, 7) == 0) pattern_i = $urandom;
         step(r);
         checks++;
         if ({grant_o, busy_o, done_o, led_o} !== {m_grant, m_busy, m_done, m_led} ||
             $countones(grant_o) > 1) begin
            failures++;
            $display("FAIL random step %0d req=%b: got %h want %h", k, r,
                     {grant_o, busy_o, done_o, led_o}, {m_grant, m_busy, m_done, m_led});
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_solo_hold();
      test_owner_drop();
      test_all_request();
      test_async_reset();
      test_pattern_track();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
